// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Single-clock synchronous FIFO with registered read data,
//               occupancy counter and almost-full / almost-empty flags.
//               Optional sticky overflow/underflow flag enabled by defining
//               the macro FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int data_width      = 6,
    parameter int address_width   = 2,
    parameter int almost_full_th  = 3,
    parameter int almost_empty_th = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_enable,
    input  logic                     rd_enable,
    input  logic [data_width-1:0]    FIFO_data_in,
    output logic [data_width-1:0]    FIFO_data_out,
    output logic                     valid_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [address_width:0]   occupancy
`ifdef FIFO_ERR_EN
    ,
    output logic                     error
`endif
);

    localparam int                 c_depth     = 1 << address_width;
    localparam logic [address_width:0] c_depth_occ = (address_width+1)'(c_depth);
    localparam logic [address_width:0] c_af_th     = (address_width+1)'(almost_full_th);
    localparam logic [address_width:0] c_ae_th     = (address_width+1)'(almost_empty_th);

    logic [data_width-1:0]    r_mem [0:c_depth-1];
    logic [address_width-1:0] r_wr_ptr;
    logic [address_width-1:0] r_rd_ptr;
    logic [address_width:0]   r_occ;
    logic [data_width-1:0]    r_data_out;
    logic                     r_valid;

    logic w_full;
    logic w_empty;
    logic w_do_read;
    logic w_do_write;

    // Status flags decode straight from the occupancy register.
    assign w_full  = (r_occ == c_depth_occ);
    assign w_empty = (r_occ == '0);

    // A read needs stored data (no bypass from an empty FIFO); a write into a
    // full FIFO is allowed only when a read frees a slot on the same edge.
    assign w_do_read  = rd_enable && !w_empty;
    assign w_do_write = wr_enable && (!w_full || w_do_read);

    // Storage array and write pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_do_write) begin
            r_mem[r_wr_ptr] <= FIFO_data_in;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer, registered read data and its one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_do_read;
            if (w_do_read) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter: net change of accepted writes and reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ <= '0;
        end else begin
            case ({w_do_write, w_do_read})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    logic r_error;

    // Sticky flag for a dropped write or an ignored read; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if ((wr_enable && !w_do_write) || (rd_enable && !w_do_read)) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`endif

    assign FIFO_data_out = r_data_out;
    assign valid_out     = r_valid;
    assign full          = w_full;
    assign empty         = w_empty;
    assign almost_full   = (r_occ >= c_af_th);
    assign almost_empty  = (r_occ <= c_ae_th);
    assign occupancy     = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Directed self-checking bench for fifo_param at default
//               parameters (depth 4, 6-bit data, almost_full 3, almost_empty 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_enable = 1'b0;
    logic       rd_enable = 1'b0;
    logic [5:0] FIFO_data_in = '0;
    logic [5:0] FIFO_data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] occupancy;
`ifdef FIFO_ERR_EN
    logic       error;
`endif

    int total = 0;
    int bad   = 0;

    fifo_param dut (
        .clk           (clk),
        .reset         (reset),
        .wr_enable     (wr_enable),
        .rd_enable     (rd_enable),
        .FIFO_data_in  (FIFO_data_in),
        .FIFO_data_out (FIFO_data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .occupancy     (occupancy)
`ifdef FIFO_ERR_EN
        ,
        .error         (error)
`endif
    );

    always #5 clk = ~clk;

    // Apply one set of inputs for one rising edge, then settle past the edge.
    task automatic step(input logic rst_n, input logic wr, input logic rd,
                        input logic [5:0] din);
        @(negedge clk);
        reset        = rst_n;
        wr_enable    = wr;
        rd_enable    = rd;
        FIFO_data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check data word, valid strobe and occupancy in one go.
    task automatic chk3(input string tag, input logic [5:0] d, input logic v,
                        input logic [2:0] occ);
        chk({tag, ".data"}, 64'(FIFO_data_out), 64'(d));
        chk({tag, ".valid"}, 64'(valid_out), 64'(v));
        chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 6'h00);
        chk3("rst", 6'h00, 1'b0, 3'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.aempty", 64'(almost_empty), 64'd1);
        chk("rst.full", 64'(full), 64'd0);
        chk("rst.afull", 64'(almost_full), 64'd0);
`ifdef FIFO_ERR_EN
        chk("rst.error", 64'(error), 64'd0);
`endif

        // Fill with 01..04
        step(1'b1, 1'b1, 1'b0, 6'h01);
        chk("w1.occ", 64'(occupancy), 64'd1);
        chk("w1.empty", 64'(empty), 64'd0);
        chk("w1.aempty", 64'(almost_empty), 64'd1);
        step(1'b1, 1'b1, 1'b0, 6'h02);
        chk("w2.occ", 64'(occupancy), 64'd2);
        chk("w2.aempty", 64'(almost_empty), 64'd0);
        chk("w2.afull", 64'(almost_full), 64'd0);
        step(1'b1, 1'b1, 1'b0, 6'h03);
        chk("w3.occ", 64'(occupancy), 64'd3);
        chk("w3.afull", 64'(almost_full), 64'd1);
        chk("w3.full", 64'(full), 64'd0);
        step(1'b1, 1'b1, 1'b0, 6'h04);
        chk("w4.occ", 64'(occupancy), 64'd4);
        chk("w4.full", 64'(full), 64'd1);

        // Write while full is dropped
        step(1'b1, 1'b1, 1'b0, 6'h3F);
        chk("drop.occ", 64'(occupancy), 64'd4);
        chk("drop.full", 64'(full), 64'd1);
        chk("drop.valid", 64'(valid_out), 64'd0);
`ifdef FIFO_ERR_EN
        chk("drop.error", 64'(error), 64'd1);
`endif

        // Drain: 01..04 in order, then read on empty is ignored
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("r1", 6'h01, 1'b1, 3'd3);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("r2", 6'h02, 1'b1, 3'd2);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("r3", 6'h03, 1'b1, 3'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("r4", 6'h04, 1'b1, 3'd0);
        chk("r4.empty", 64'(empty), 64'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("rempty", 6'h04, 1'b0, 3'd0);

        // Pointer wrap with interleaved traffic 05..0A
        step(1'b1, 1'b1, 1'b0, 6'h05);
        chk("wr5.occ", 64'(occupancy), 64'd1);
        step(1'b1, 1'b1, 1'b0, 6'h06);
        chk("wr6.occ", 64'(occupancy), 64'd2);
        step(1'b1, 1'b1, 1'b1, 6'h07);
        chk3("wrap1", 6'h05, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 6'h08);
        chk3("wrap2", 6'h06, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 6'h09);
        chk3("wrap3", 6'h07, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 6'h0A);
        chk3("wrap4", 6'h08, 1'b1, 3'd2);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("wrap5", 6'h09, 1'b1, 3'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("wrap6", 6'h0A, 1'b1, 3'd0);

        // Empty with simultaneous read and write: write only, no bypass
        step(1'b1, 1'b1, 1'b1, 6'h2A);
        chk3("erw", 6'h0A, 1'b0, 3'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("erw.rd", 6'h2A, 1'b1, 3'd0);

        // Full with simultaneous read and write: both proceed
        step(1'b1, 1'b1, 1'b0, 6'h11);
        step(1'b1, 1'b1, 1'b0, 6'h12);
        step(1'b1, 1'b1, 1'b0, 6'h13);
        step(1'b1, 1'b1, 1'b0, 6'h14);
        chk("frw.pre", 64'(full), 64'd1);
        step(1'b1, 1'b1, 1'b1, 6'h15);
        chk3("frw", 6'h11, 1'b1, 3'd4);
        chk("frw.full", 64'(full), 64'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("frw.r1", 6'h12, 1'b1, 3'd3);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("frw.r2", 6'h13, 1'b1, 3'd2);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("frw.r3", 6'h14, 1'b1, 3'd1);
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("frw.r4", 6'h15, 1'b1, 3'd0);

        // Mid-stream reset overrides a pending write
        step(1'b1, 1'b1, 1'b0, 6'h21);
        step(1'b1, 1'b1, 1'b0, 6'h22);
        step(1'b1, 1'b1, 1'b0, 6'h23);
        chk("mrst.pre", 64'(occupancy), 64'd3);
        step(1'b0, 1'b1, 1'b0, 6'h24);
        chk3("mrst", 6'h00, 1'b0, 3'd0);
        chk("mrst.empty", 64'(empty), 64'd1);
        chk("mrst.full", 64'(full), 64'd0);
`ifdef FIFO_ERR_EN
        chk("mrst.error", 64'(error), 64'd0);
`endif
        step(1'b1, 1'b0, 1'b1, 6'h00);
        chk3("mrst.rd", 6'h00, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter data_width, default 6: data word width in bits, legal range 1..64.
REQ-002 Parameter address_width, default 2: pointer width; depth = 2**address_width, legal range 1..8.
REQ-003 Parameter almost_full_th, default 3: almost_full asserts when occupancy >= this value; legal range 1..depth.
REQ-004 Parameter almost_empty_th, default 1: almost_empty asserts when occupancy <= this value; legal range 0..depth-1.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1: synchronous, active-low reset sampled on the rising edge of clk.
REQ-007 Port wr_enable  input  1: write request.
REQ-008 Port rd_enable  input  1: read request.
REQ-009 Port FIFO_data_in  input  data_width: write data.
REQ-010 Port FIFO_data_out  output  data_width: registered read data.
REQ-011 Port valid_out  output  1: FIFO_data_out holds a word popped on the previous edge.
REQ-012 Port full  output  1: occupancy == depth.
REQ-013 Port empty  output  1: occupancy == 0.
REQ-014 Port almost_full  output  1: occupancy >= almost_full_th.
REQ-015 Port almost_empty  output  1: occupancy <= almost_empty_th.
REQ-016 Port occupancy  output  address_width+1: number of stored words, 0..depth.
REQ-017 Port error  output  1: sticky overflow/underflow flag; present only with FIFO_ERR_EN.

Function
REQ-018 Storage SHALL be a depth x data_width register array with internal wr_ptr and rd_ptr, each address_width bits, wrapping from depth-1 to 0 by natural overflow.
REQ-019 A write SHALL occur when wr_enable=1 and (full=0 or a read occurs on the same edge); it stores FIFO_data_in at wr_ptr and increments wr_ptr.
REQ-020 A read SHALL occur when rd_enable=1 and empty=0; it loads mem[rd_ptr] into FIFO_data_out, increments rd_ptr, and sets valid_out=1 for the following cycle.
REQ-021 Read latency SHALL be exactly one clock: data visible on FIFO_data_out the cycle after the accepting edge.
REQ-022 When no read occurs, valid_out SHALL be 0 and FIFO_data_out SHALL hold its last value.
REQ-023 occupancy SHALL update: +1 on write only, -1 on read only, unchanged on simultaneous read and write or neither.
REQ-024 Full with wr_enable and rd_enable both 1: both SHALL proceed; occupancy stays depth.
REQ-025 Empty with wr_enable and rd_enable both 1: write SHALL proceed, read SHALL be ignored (no bypass); occupancy becomes 1, valid_out=0.
REQ-026 Write while full without read SHALL be dropped; memory and pointers unchanged.
REQ-027 Read while empty SHALL be ignored; pointers unchanged, valid_out=0.
REQ-028 full, empty, almost_full, almost_empty SHALL be combinational decodes of the occupancy register (glitch-free, no extra latency).

Reset
REQ-029 With reset=0 on an edge: wr_ptr=0, rd_ptr=0, occupancy=0, FIFO_data_out=0, valid_out=0, error=0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 Memory contents SHALL be cleared to 0 on reset.
REQ-031 Reset SHALL override wr_enable and rd_enable on the same edge; a reset mid-stream discards all stored words.

Configuration
REQ-032 Macro FIFO_ERR_EN defined: error port exists; error sets on a dropped write (REQ-026) or ignored read (REQ-027) and clears only on reset.
REQ-033 Macro FIFO_ERR_EN undefined: error port and its logic SHALL be absent; all other behaviour identical.

Verification (defaults: depth 4, data_width 6)
REQ-034 Reset then write 0x01,0x02,0x03,0x04 -> occupancy 1,2,3,4; almost_full at occupancy 3; full=1 after 4th write.
REQ-035 From full, write 0x3F without read -> dropped; occupancy=4; error=1 (FIFO_ERR_EN); subsequent reads return 0x01..0x04 in order, each valid_out=1 one cycle after request.
REQ-036 Pointer wrap: write 6 and read 6 words 0x05..0x0A interleaved -> reads return 0x05..0x0A in order, occupancy never exceeds 4.
REQ-037 Empty, wr_enable=rd_enable=1 with 0x2A -> occupancy=1, valid_out=0; next read returns 0x2A.
REQ-038 Full, wr_enable=rd_enable=1 with 0x15 -> occupancy stays 4, oldest word output, 0x15 read last.
REQ-039 reset=0 asserted with occupancy 3 and wr_enable=1 -> next cycle occupancy=0, empty=1, valid_out=0, FIFO_data_out=0x00, error=0.
